// File: rtl/det3x3_seq_engine.sv
// Sequential 3x3 signed determinant engine: streams in a row-major matrix, expands cofactors
// along row EXP_ROW with one shared multiplier. Optional macro DET_ZERO_SKIP_EN skips zero pivots.
module det3x3_seq_engine #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned EXP_ROW = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [3*DATA_W+2:0]   out_det,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int unsigned DET_W = 3*DATA_W + 3;
    localparam int unsigned PW    = 2*DATA_W;      // element x element
    localparam int unsigned MNW   = 2*DATA_W + 1;  // 2x2 minor
    localparam int unsigned MW    = 3*DATA_W + 1;  // multiplier output
    localparam logic [1:0]  R0    = (EXP_ROW == 0) ? 2'd1 : 2'd0;
    localparam logic [1:0]  R1    = (EXP_ROW == 2) ? 2'd1 : 2'd2;
    localparam logic [1:0]  ER    = 2'(EXP_ROW);
    localparam logic        EXP_ODD = 1'(EXP_ROW % 2);

    generate
        if (EXP_ROW > 2 || DATA_W < 2) begin : g_bad_param
            $error("det3x3_seq_engine: EXP_ROW must be 0..2 and DATA_W >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LOAD, P1, P2, C, OUT} state_e;

    state_e                     state_q, state_d;
    logic [3:0]                 k_q, k_d;
    logic [1:0]                 j_q, j_d;
    logic signed [DATA_W-1:0]   mat_q [9];
    logic signed [DATA_W-1:0]   mat_d [9];
    logic signed [PW-1:0]       prod_q, prod_d;
    logic signed [MNW-1:0]      minor_q, minor_d;
    logic signed [DET_W-1:0]    acc_q, acc_d;
    logic                       in_ready_q, out_valid_q, busy_q;

    logic signed [DATA_W-1:0]   mul_a, pivot;
    logic signed [MNW-1:0]      mul_b;
    logic signed [MW-1:0]       mul_p;
    logic signed [DET_W-1:0]    term;
    logic [1:0]                 c0, c1;
    logic                       neg, beat;

    function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
        return 4'(r) * 4'd3 + 4'(c);
    endfunction

    // Operand steering for the single shared multiplier
    always_comb begin
        c0    = (j_q == 2'd0) ? 2'd1 : 2'd0;
        c1    = (j_q == 2'd2) ? 2'd1 : 2'd2;
        pivot = mat_q[idx(ER, j_q)];
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            P1: begin
                mul_a = mat_q[idx(R0, c0)];
                mul_b = MNW'(mat_q[idx(R1, c1)]);
            end
            P2: begin
                mul_a = mat_q[idx(R0, c1)];
                mul_b = MNW'(mat_q[idx(R1, c0)]);
            end
            C: begin
                mul_a = pivot;
                mul_b = minor_q;
            end
            default: ;
        endcase
        mul_p = MW'(mul_a) * MW'(mul_b);
        term  = DET_W'(mul_p);
        neg   = EXP_ODD ^ j_q[0];
        beat  = in_valid & in_ready_q;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        mat_d   = mat_q;
        prod_d  = prod_q;
        minor_d = minor_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (beat) begin
                mat_d[0] = in_data;
                k_d      = 4'd1;
                state_d  = LOAD;
            end
            LOAD: if (beat) begin
                mat_d[k_q] = in_data;
                if (k_q == 4'd8) begin
                    k_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = P1;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            P1: begin
`ifdef DET_ZERO_SKIP_EN
                if (pivot == '0) begin
                    if (j_q == 2'd2) begin
                        state_d = OUT;
                    end else begin
                        j_d     = j_q + 2'd1;
                        state_d = P1;
                    end
                end else begin
                    prod_d  = PW'(mul_p);
                    state_d = P2;
                end
`else
                prod_d  = PW'(mul_p);
                state_d = P2;
`endif
            end
            P2: begin
                minor_d = MNW'(prod_q) - MNW'(mul_p);
                state_d = C;
            end
            C: begin
                acc_d = neg ? (acc_q - term) : (acc_q + term);
                if (j_q == 2'd2) begin
                    state_d = OUT;
                end else begin
                    j_d     = j_q + 2'd1;
                    state_d = P1;
                end
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            j_q         <= '0;
            prod_q      <= '0;
            minor_q     <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < 9; i++) mat_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            j_q         <= j_d;
            prod_q      <= prod_d;
            minor_q     <= minor_d;
            acc_q       <= acc_d;
            in_ready_q  <= (state_d == IDLE) || (state_d == LOAD);
            out_valid_q <= (state_d == OUT);
            busy_q      <= (state_d != IDLE);
            mat_q       <= mat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_det   = acc_q;

endmodule
